// File: rtl/ps2_key_pkg.sv
// Shared scan-code names, widths and repeat FSM states for the PS2 key front end.
package ps2_key_pkg;

    localparam int SCAN_W = 9;

    localparam logic [SCAN_W-1:0] KEY_UP     = 9'h175;
    localparam logic [SCAN_W-1:0] KEY_DOWN   = 9'h172;
    localparam logic [SCAN_W-1:0] KEY_LEFT   = 9'h16b;
    localparam logic [SCAN_W-1:0] KEY_RIGHT  = 9'h174;
    localparam logic [SCAN_W-1:0] KEY_OK     = 9'h029;
    localparam logic [SCAN_W-1:0] KEY_SWITCH = 9'h014;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

endpackage

// File: rtl/ps2_key_events_repeat.sv
// Typematic repeat timer: one shared counter, restarted by every fresh press.
module ps2_key_repeat
    import ps2_key_pkg::*;
#(
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10,
    parameter int CNT_W         = 16,
    parameter int IDX_W         = 3
) (
    input  logic             clk_slow,
    input  logic             rst,
    input  logic             fresh,
    input  logic [IDX_W-1:0] fresh_idx,
    input  logic             change,
    output logic             rpt_pulse,
    output logic [IDX_W-1:0] rpt_idx
);

    rpt_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            state_q <= RPT_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rpt_pulse = 1'b0;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        // any change of the held set cancels timing; a fresh press restarts it
        if (change) begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
            if (fresh) begin
                state_d = RPT_DELAY;
                idx_d   = fresh_idx;
            end
        end else begin
            unique case (state_q)
                RPT_DELAY: begin
                    if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                        rpt_pulse = 1'b1;
                        state_d   = RPT_REPEAT;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                RPT_REPEAT: begin
                    if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
                        rpt_pulse = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rpt_idx = idx_q;

endmodule

// File: rtl/ps2_scan.sv
// PS2 frame receiver on clk_fast; holds the last make code (bit 8 = E0 prefix),
// returns to 9'h000 when that key's break code arrives.
module ps2_scan
    import ps2_key_pkg::*;
(
    input  logic              clk_fast,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [SCAN_W-1:0] crt_data
);

    logic [2:0]        clk_sync_q, clk_sync_d;
    logic [1:0]        dat_sync_q, dat_sync_d;
    logic [9:0]        sr_q, sr_d;
    logic [3:0]        bits_q, bits_d;
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic [SCAN_W-1:0] code_q, code_d;

    logic        fall;
    logic [10:0] frame;
    logic [7:0]  byte_v;
    logic        frame_ok;

    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
            sr_q       <= '0;
            bits_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            code_q     <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            sr_q       <= sr_d;
            bits_q     <= bits_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            code_q     <= code_d;
        end
    end

    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        sr_d       = sr_q;
        bits_d     = bits_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        code_d     = code_q;
        fall       = clk_sync_q[2] & ~clk_sync_q[1];
        frame      = {dat_sync_q[1], sr_q};
        byte_v     = frame[8:1];
        // start low, stop high, odd parity over data+parity
        frame_ok   = ~frame[0] & frame[10] & (^frame[9:1]);
        if (fall) begin
            if (bits_q == 4'd10) begin
                bits_d = '0;
                sr_d   = '0;
                if (frame_ok) begin
                    if (byte_v == 8'he0) begin
                        ext_d = 1'b1;
                    end else if (byte_v == 8'hf0) begin
                        brk_d = 1'b1;
                    end else begin
                        if (brk_q) begin
                            if (code_q == {ext_q, byte_v}) begin
                                code_d = '0;
                            end
                        end else begin
                            code_d = {ext_q, byte_v};
                        end
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
            end else begin
                sr_d   = {dat_sync_q[1], sr_q[9:1]};
                bits_d = bits_q + 4'd1;
            end
        end
    end

    assign crt_data = code_q;

endmodule

// File: rtl/ps2_key_events.sv
// PS2 key-event front end: scanner, clk_slow resync, table match, press/release/held.
// Auto-repeat is built only when PS2_KEY_REPEAT_EN is defined.
module ps2_key_events
    import ps2_key_pkg::*;
#(
    parameter int                         NUM_KEYS      = 6,
    parameter logic [SCAN_W*NUM_KEYS-1:0] KEY_CODES     =
        {KEY_SWITCH, KEY_OK, KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP},
    parameter int                         REPEAT_DELAY  = 50,
    parameter int                         REPEAT_PERIOD = 10,
    parameter int                         CNT_W         = 16
) (
    input  logic                clk_slow,
    input  logic                rst,
    input  logic                clk_fast,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                key_repeat,
    output logic                any_key
);

    if (NUM_KEYS < 1 || NUM_KEYS > 16 || REPEAT_DELAY < 2 ||
        REPEAT_PERIOD < 2 ||
        CNT_W < $clog2(REPEAT_DELAY + 1) ||
        CNT_W < $clog2(REPEAT_PERIOD + 1)) begin : g_bad_cfg
        $error("ps2_key_events: invalid parameter set");
    end

    logic [SCAN_W-1:0]   scan_code;
    logic [SCAN_W-1:0]   s1_q, s1_d;
    logic [SCAN_W-1:0]   s2_q, s2_d;
    logic [SCAN_W-1:0]   code_q, code_d;
    logic [NUM_KEYS-1:0] key_held_q, key_held_d;
    logic [NUM_KEYS-1:0] key_press_q, key_press_d;
    logic [NUM_KEYS-1:0] key_release_q, key_release_d;
    logic [NUM_KEYS-1:0] held_n, press_n, rel_n;

    ps2_scan u_scan (
        .clk_fast (clk_fast),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .crt_data (scan_code)
    );

    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            code_q        <= '0;
            key_held_q    <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            code_q        <= code_d;
            key_held_q    <= key_held_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    always_comb begin
        s1_d   = scan_code;
        s2_d   = s1_q;
        // only accept a code seen on two consecutive samples
        code_d = (s1_q == s2_q) ? s2_q : code_q;
        held_n = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            held_n[i] = (code_q != '0) &&
                        (code_q == KEY_CODES[i*SCAN_W +: SCAN_W]);
        end
        press_n       = held_n & ~key_held_q;
        rel_n         = ~held_n & key_held_q;
        key_held_d    = held_n;
        key_release_d = rel_n;
    end

`ifdef PS2_KEY_REPEAT_EN
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic [IDX_W-1:0] fresh_idx, rpt_idx;
    logic             rpt_pulse;
    logic             key_repeat_q;

    // lowest-numbered freshly pressed key owns the repeat timer
    always_comb begin
        fresh_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (press_n[i]) begin
                fresh_idx = IDX_W'(i);
            end
        end
    end

    ps2_key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W),
        .IDX_W         (IDX_W)
    ) u_rep (
        .clk_slow  (clk_slow),
        .rst       (rst),
        .fresh     (|press_n),
        .fresh_idx (fresh_idx),
        .change    (|(held_n ^ key_held_q)),
        .rpt_pulse (rpt_pulse),
        .rpt_idx   (rpt_idx)
    );

    always_comb begin
        key_press_d = press_n |
            (rpt_pulse ? (NUM_KEYS'(1) << rpt_idx) : '0);
    end

    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            key_repeat_q <= 1'b0;
        end else begin
            key_repeat_q <= rpt_pulse;
        end
    end

    assign key_repeat = key_repeat_q;
`else
    always_comb begin
        key_press_d = press_n;
    end

    assign key_repeat = 1'b0;
`endif

    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign key_held    = key_held_q;
    assign any_key     = |key_held_q;

endmodule

// File: tb/tb_ps2_key_events.sv
// Scoreboard bench for ps2_key_events; repeat scenarios follow PS2_KEY_REPEAT_EN.
module tb_ps2_key_events;
    import ps2_key_pkg::*;

`ifdef PS2_KEY_REPEAT_EN
    localparam int DLY = 4;
    localparam int PER = 2;
`else
    localparam int DLY = 50;
    localparam int PER = 10;
`endif

    logic       clk_slow = 1'b0;
    logic       clk_fast = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [5:0] key_press, key_release, key_held;
    logic       key_repeat, any_key;
    logic [8:0] forced_code;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    bit ign_rep = 1'b0;

    typedef struct {
        logic [5:0] pr;
        logic [5:0] rl;
        logic       rp;
        int         at;
    } ev_t;

    ev_t evq[$];

    ps2_key_events #(
        .NUM_KEYS      (6),
        .REPEAT_DELAY  (DLY),
        .REPEAT_PERIOD (PER),
        .CNT_W         (8)
    ) dut (
        .clk_slow    (clk_slow),
        .rst         (rst),
        .clk_fast    (clk_fast),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_press   (key_press),
        .key_release (key_release),
        .key_held    (key_held),
        .key_repeat  (key_repeat),
        .any_key     (any_key)
    );

    always #10 clk_slow = ~clk_slow;
    always #2 clk_fast = ~clk_fast;

    always @(posedge clk_slow) cyc <= cyc + 1;

    always @(posedge clk_slow) begin
        ev_t e;
        #1;
        if ((key_press | key_release) != 6'b0 &&
            !(ign_rep && key_repeat && key_release == 6'b0)) begin
            n_cmp++;
            if (evq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event cyc=%0d got p=%b r=%b rep=%b want none",
                         cyc, key_press, key_release, key_repeat);
            end else begin
                e = evq.pop_front();
                if (key_press !== e.pr || key_release !== e.rl ||
                    key_repeat !== e.rp || (e.at >= 0 && cyc !== e.at)) begin
                    n_err++;
                    $display("FAIL event cyc=%0d got p=%b r=%b rep=%b want cyc=%0d p=%b r=%b rep=%b",
                             cyc, key_press, key_release, key_repeat,
                             e.at, e.pr, e.rl, e.rp);
                end
            end
        end
    end

    task automatic drive(input logic [8:0] v);
        forced_code = v;
        force dut.scan_code = forced_code;
    endtask

    task automatic push_ev(input logic [5:0] pr, input logic [5:0] rl,
                           input logic rp, input int at);
        ev_t e;
        e.pr = pr;
        e.rl = rl;
        e.rp = rp;
        e.at = at;
        evq.push_back(e);
    endtask

    // press at t0 (merged with rl), then repeats strictly before t_end
    task automatic expect_hold(input int idx, input int t0, input int t_end,
                               input logic [5:0] rl);
        logic [5:0] one;
        one = 6'b1 << idx;
        push_ev(one, rl, 1'b0, t0);
`ifdef PS2_KEY_REPEAT_EN
        for (int t = t0 + DLY; t < t_end; t += PER) begin
            push_ev(one, 6'b0, 1'b1, t);
        end
`else
        if (t_end < t0) push_ev(one, 6'b0, 1'b0, t_end);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [10:0] fr;
        fr = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = fr[i];
            #100 ps2_clk = 1'b0;
            #100 ps2_clk = 1'b1;
        end
        #200;
    endtask

    task automatic test_reset();
        int c;
        drive(KEY_UP);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_slow);
            n_cmp++;
            if ({key_press, key_release, key_held, key_repeat, any_key} !== 20'b0) begin
                n_err++;
                $display("FAIL reset_outputs got p=%b r=%b h=%b want 0",
                         key_press, key_release, key_held);
            end
        end
        @(negedge clk_slow);
        rst = 1'b1;
        c = cyc;
        expect_hold(0, c + 4, c + 12, 6'b0);
        push_ev(6'b0, 6'b000001, 1'b0, c + 12);
        repeat (5) @(negedge clk_slow);
        n_cmp++;
        if (key_held !== 6'b000001 || any_key !== 1'b1) begin
            n_err++;
            $display("FAIL reset_held got h=%b any=%b want 000001 1", key_held, any_key);
        end
        repeat (3) @(negedge clk_slow);
        drive(9'h000);
        repeat (6) @(negedge clk_slow);
        n_cmp++;
        if (evq.size() !== 0) begin
            n_err++;
            $display("FAIL reset_pending got %0d want 0", evq.size());
        end
    endtask

    task automatic test_glitch();
        int c;
        @(negedge clk_slow);
        drive(KEY_LEFT);
        @(negedge clk_slow);
        drive(9'h000);
        repeat (6) @(negedge clk_slow);
        n_cmp++;
        if (key_held !== 6'b0) begin
            n_err++;
            $display("FAIL glitch_held got %b want 000000", key_held);
        end
        @(negedge clk_slow);
        drive(KEY_LEFT);
        c = cyc;
        expect_hold(2, c + 4, c + 7, 6'b0);
        push_ev(6'b0, 6'b000100, 1'b0, c + 7);
        repeat (3) @(negedge clk_slow);
        drive(9'h000);
        repeat (2) @(negedge clk_slow);
        n_cmp++;
        if (key_held !== 6'b000100) begin
            n_err++;
            $display("FAIL glitch_hold3 got %b want 000100", key_held);
        end
        repeat (6) @(negedge clk_slow);
        n_cmp++;
        if (evq.size() !== 0) begin
            n_err++;
            $display("FAIL glitch_pending got %0d want 0", evq.size());
        end
    endtask

    task automatic test_ps2_frame();
        int k;
        @(negedge clk_slow);
        release dut.scan_code;
        ign_rep = 1'b1;
        push_ev(6'b000001, 6'b0, 1'b0, -1);
        send_byte(8'he0);
        send_byte(8'h75);
        k = 0;
        while (k < 300 && key_held !== 6'b000001) begin
            @(negedge clk_slow);
            k++;
        end
        n_cmp++;
        if (key_held !== 6'b000001) begin
            n_err++;
            $display("FAIL ps2_make got h=%b want 000001", key_held);
        end
        push_ev(6'b0, 6'b000001, 1'b0, -1);
        send_byte(8'he0);
        send_byte(8'hf0);
        repeat (4) @(negedge clk_slow);
        n_cmp++;
        if (key_held !== 6'b000001) begin
            n_err++;
            $display("FAIL ps2_held_before_break got h=%b want 000001", key_held);
        end
        send_byte(8'h75);
        k = 0;
        while (k < 300 && key_held !== 6'b0) begin
            @(negedge clk_slow);
            k++;
        end
        n_cmp++;
        if (key_held !== 6'b0) begin
            n_err++;
            $display("FAIL ps2_break got h=%b want 000000", key_held);
        end
        repeat (4) @(negedge clk_slow);
        ign_rep = 1'b0;
        n_cmp++;
        if (evq.size() !== 0) begin
            n_err++;
            $display("FAIL ps2_pending got %0d want 0", evq.size());
        end
        drive(9'h000);
    endtask

    task automatic test_repeat();
        int c;
        @(negedge clk_slow);
        drive(KEY_OK);
        c = cyc;
        expect_hold(4, c + 4, c + 16, 6'b0);
        push_ev(6'b0, 6'b010000, 1'b0, c + 16);
        repeat (12) @(negedge clk_slow);
        drive(9'h000);
        repeat (8) @(negedge clk_slow);
        n_cmp++;
        if (evq.size() !== 0) begin
            n_err++;
            $display("FAIL repeat_pending got %0d want 0", evq.size());
        end
    endtask

    task automatic test_direct_change();
        int c;
        @(negedge clk_slow);
        drive(KEY_UP);
        c = cyc;
        expect_hold(0, c + 4, c + 10, 6'b0);
        expect_hold(1, c + 10, c + 17, 6'b000001);
        push_ev(6'b0, 6'b000010, 1'b0, c + 17);
        repeat (6) @(negedge clk_slow);
        drive(KEY_DOWN);
        repeat (5) @(negedge clk_slow);
        n_cmp++;
        if (key_held !== 6'b000010 || any_key !== 1'b1) begin
            n_err++;
            $display("FAIL direct_held got h=%b any=%b want 000010 1", key_held, any_key);
        end
        repeat (2) @(negedge clk_slow);
        drive(9'h000);
        repeat (8) @(negedge clk_slow);
        n_cmp++;
        if (evq.size() !== 0) begin
            n_err++;
            $display("FAIL direct_pending got %0d want 0", evq.size());
        end
    endtask

    task automatic test_unknown_reset();
        int c;
        @(negedge clk_slow);
        drive(KEY_SWITCH);
        c = cyc;
        expect_hold(5, c + 4, c + 9, 6'b0);
        push_ev(6'b0, 6'b100000, 1'b0, c + 9);
        repeat (5) @(negedge clk_slow);
        drive(9'h01c);
        repeat (8) @(negedge clk_slow);
        n_cmp++;
        if (key_held !== 6'b0 || any_key !== 1'b0 || evq.size() !== 0) begin
            n_err++;
            $display("FAIL unknown_code got h=%b any=%b pend=%0d want 0 0 0",
                     key_held, any_key, evq.size());
        end
        drive(9'h000);
        repeat (4) @(negedge clk_slow);
        drive(KEY_OK);
        c = cyc;
        expect_hold(4, c + 4, c + 10, 6'b0);
        repeat (9) @(negedge clk_slow);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({key_press, key_release, key_held, key_repeat, any_key} !== 20'b0) begin
            n_err++;
            $display("FAIL midreset_outputs got p=%b r=%b h=%b rep=%b want 0",
                     key_press, key_release, key_held, key_repeat);
        end
`ifdef PS2_KEY_REPEAT_EN
        n_cmp++;
        if (dut.u_rep.state_q !== RPT_IDLE) begin
            n_err++;
            $display("FAIL midreset_fsm got %0d want %0d", dut.u_rep.state_q, RPT_IDLE);
        end
`endif
        drive(9'h000);
        repeat (3) @(negedge clk_slow);
        rst = 1'b1;
        repeat (12) @(negedge clk_slow);
        n_cmp++;
        if (key_held !== 6'b0 || evq.size() !== 0) begin
            n_err++;
            $display("FAIL midreset_after got h=%b pend=%0d want 0 0", key_held, evq.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
        test_ps2_frame();
        test_repeat();
        test_direct_change();
        test_unknown_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
